act_seg_arbiter: RTL and testbench

- Round-robin arbiter that shares one segment-coefficient ROM (registered, fixed latency LAT, valid-in/valid-out) among NREQ requesters in the activation unit.
- Each requester sends a segment index and receives the matching FP16 coefficient.
- A tag pipeline routes each ROM result back to its issuer.
- Credit rule: at most one outstanding lookup per requester, so responses never overflow.

---
 rtl/act_seg_arbiter.sv | 148 ++++++++++++++
 tb/tb_act_seg_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_seg_arbiter.sv
// Round-robin arbiter sharing one fixed-latency coefficient ROM among NREQ requesters.
// A tag pipeline returns each ROM result to its issuer; one lookup in flight per requester.
module act_seg_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int SW   = 3,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*SW-1:0] req_seg_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [NREQ*DW-1:0] rsp_f0_o,
    input  logic [NREQ-1:0]    rsp_ready_i,
    output logic               rom_valid_o,
    output logic [SW-1:0]      rom_seg_o,
    input  logic               rom_valid_i,
    input  logic [DW-1:0]      rom_f0_i,
    output logic               err_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = $clog2(LAT + 2);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(LAT);

    logic [NREQ-1:0]         busy_q, busy_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    rom_valid_q, rom_valid_d;
    logic [SW-1:0]           rom_seg_q, rom_seg_d;
    logic [LAT:0]            tag_v_q, tag_v_d;
    logic [LAT:0][PW-1:0]    tag_id_q, tag_id_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0]      rsp_f0_q, rsp_f0_d;
    logic                    err_q, err_d;
    logic [FW-1:0]           flush_q, flush_d;

    logic [NREQ-1:0]         elig;
    logic [NREQ-1:0]         grant;
    logic [PW-1:0]           gnt_id;
    logic                    accept;
    logic                    found;
    int                      idx;

    assign elig   = req_valid_i & ~busy_q;
    assign accept = |grant;

    // Rotating priority scan starting at the pointer
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = PW'(idx);
            end
        end
    end

    always_comb begin
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        rom_valid_d = accept;
        rom_seg_d   = rom_seg_q;
        tag_v_d     = '0;
        tag_id_d    = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_f0_d    = rsp_f0_q;
        err_d       = err_q;
        flush_d     = (flush_q != '0) ? flush_q - 1'b1 : flush_q;

        if (accept) begin
            busy_d[gnt_id] = 1'b1;
            rom_seg_d      = req_seg_i[int'(gnt_id)*SW +: SW];
            if (gnt_id == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + 1'b1;
            end
        end

        tag_v_d[0]  = accept;
        tag_id_d[0] = gnt_id;
        for (int s = 1; s <= LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end

        for (int k = 0; k < NREQ; k++) begin
            if (rsp_valid_q[k] && rsp_ready_i[k]) begin
                rsp_valid_d[k] = 1'b0;
                busy_d[k]      = 1'b0;
            end
        end

        if (tag_v_q[LAT]) begin
            rsp_valid_d[tag_id_q[LAT]]             = 1'b1;
            rsp_f0_d[int'(tag_id_q[LAT])*DW +: DW] = rom_f0_i;
        end

        // Results issued before a reset may still drain out of the ROM
        if (flush_q == '0 && rom_valid_i != tag_v_q[LAT]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            rom_valid_q <= 1'b0;
            rom_seg_q   <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_f0_q    <= '0;
            err_q       <= 1'b0;
            flush_q     <= FLUSH_INIT;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            rom_valid_q <= rom_valid_d;
            rom_seg_q   <= rom_seg_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_f0_q    <= rsp_f0_d;
            err_q       <= err_d;
            flush_q     <= flush_d;
        end
    end

    assign req_ready_o = grant & {NREQ{rstn}};
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_f0_o    = rsp_f0_q;
    assign rom_valid_o = rom_valid_q;
    assign rom_seg_o   = rom_seg_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_act_seg_arbiter.sv
// Directed bench for act_seg_arbiter with a one-cycle ROM model and an in-order
// response scoreboard.
module tb_act_seg_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [11:0] req_seg;
    logic [3:0]  req_ready_o;
    logic [3:0]  rsp_valid_o;
    logic [63:0] rsp_f0_o;
    logic [3:0]  rsp_ready;
    logic        rom_valid_o;
    logic [2:0]  rom_seg_o;
    logic        rom_vld;
    logic [15:0] rom_f0;
    logic        err_o;
    logic        drop;

    typedef struct {
        int          id;
        logic [15:0] f0;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt[4];
    logic [3:0]  prev_rv;

    always #5 clk = ~clk;

    act_seg_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid),
        .req_seg_i   (req_seg),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_f0_o    (rsp_f0_o),
        .rsp_ready_i (rsp_ready),
        .rom_valid_o (rom_valid_o),
        .rom_seg_o   (rom_seg_o),
        .rom_valid_i (rom_vld),
        .rom_f0_i    (rom_f0),
        .err_o       (err_o)
    );

    function automatic logic [15:0] tbl(input logic [2:0] s);
        case (s)
            3'd0:    return 16'h3C00;
            3'd1:    return 16'h2E00;
            3'd2:    return 16'h3200;
            3'd3:    return 16'h3400;
            3'd4:    return 16'h3800;
            3'd5:    return 16'h3A00;
            3'd6:    return 16'h3900;
            default: return 16'h3B40;
        endcase
    endfunction

    // Registered ROM, one cycle; drop suppresses a single valid
    always @(posedge clk) begin
        rom_vld <= rom_valid_o & ~drop;
        rom_f0  <= tbl(rom_seg_o);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        logic [3:0] newv;
        exp_t       e;
        #1;
        acc = req_valid & req_ready_o;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
                sb.push_back('{k, tbl(req_seg[k*3 +: 3]), cyc});
                acc_cnt[k]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        newv = rsp_valid_o & ~prev_rv;
        for (int k = 0; k < 4; k++) begin
            if (newv[k]) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(k), 64'(e.id));
                    chk("rsp_data", 64'(rsp_f0_o[k*16 +: 16]), 64'(e.f0));
                    chk("rsp_latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
        end
        prev_rv = rsp_valid_o;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_seg   = '0;
        rsp_ready = '0;
        drop      = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        prev_rv = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2, a3;
        for (int k = 0; k < 4; k++) acc_cnt[k] = 0;
        prev_rv = '0;
        do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_f0", rsp_f0_o, 64'd0);
        chk("rst_rom_valid", 64'(rom_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // Single lookup
        do_reset();
        req_seg   = 12'h004;
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        #1;
        chk("t1_grant", 64'(req_ready_o), 64'h1);
        step();
        chk("t1_rom_valid", 64'(rom_valid_o), 64'd1);
        chk("t1_rom_seg", 64'(rom_seg_o), 64'd4);
        chk("t1_busy_c1", 64'(req_ready_o), 64'd0);
        step();
        chk("t1_busy_c2", 64'(req_ready_o), 64'd0);
        step();
        chk("t1_rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("t1_rsp_f0", 64'(rsp_f0_o[15:0]), 64'h3800);
        chk("t1_busy_c3", 64'(req_ready_o), 64'd0);
        step();
        chk("t1_regrant", 64'(req_ready_o), 64'h1);
        chk("t1_rsp_clear", 64'(rsp_valid_o), 64'd0);
        req_valid = '0;
        repeat (4) step();
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Round-robin across all four
        do_reset();
        req_seg   = {3'd7, 3'd3, 3'd2, 3'd1};
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", 64'(req_ready_o), 64'(1 << i));
            step();
        end
        req_valid = '0;
        repeat (5) step();
        chk("t2_f0_all", rsp_f0_o, 64'h3B40_3400_3200_2E00);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure on requester 1
        do_reset();
        req_seg   = {3'd3, 3'd0, 3'd6, 3'd5};
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        repeat (6) step();
        a0 = acc_cnt[0];
        a1 = acc_cnt[1];
        a2 = acc_cnt[2];
        a3 = acc_cnt[3];
        for (int i = 0; i < 10; i++) begin
            chk("t3_no_grant1", 64'(req_ready_o[1]), 64'd0);
            chk("t3_hold_valid", 64'(rsp_valid_o[1]), 64'd1);
            chk("t3_hold_f0", 64'(rsp_f0_o[31:16]), 64'h3900);
            step();
        end
        chk("t3_others_served",
            64'((acc_cnt[0] > a0) && (acc_cnt[2] > a2) && (acc_cnt[3] > a3)),
            64'd1);
        chk("t3_req1_idle", 64'(acc_cnt[1] - a1), 64'd0);
        rsp_ready = 4'b1111;
        req_valid = 4'b0010;
        step();
        chk("t3_regrant", 64'(req_ready_o), 64'h2);
        req_valid = '0;
        repeat (6) step();
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Fairness between 0 and 2
        do_reset();
        req_seg   = {3'd0, 3'd6, 3'd0, 3'd2};
        req_valid = 4'b0101;
        rsp_ready = 4'b1111;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_grant", 64'(req_ready_o),
                64'(((i % 4) == 0) ? 1 : (((i % 4) == 1) ? 4 : 0)));
            step();
        end
        req_valid = '0;
        repeat (5) step();
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Dropped ROM valid
        do_reset();
        chk("t5_err_init", 64'(err_o), 64'd0);
        req_seg   = 12'h002;
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        step();
        drop      = 1'b1;
        req_valid = '0;
        step();
        drop = 1'b0;
        chk("t5_err_pre", 64'(err_o), 64'd0);
        step();
        chk("t5_err_set", 64'(err_o), 64'd1);
        chk("t5_rsp_still", 64'(rsp_valid_o), 64'h1);
        repeat (3) step();
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with two lookups in flight
        do_reset();
        req_seg   = {3'd0, 3'd0, 3'd2, 3'd1};
        req_valid = 4'b0011;
        rsp_ready = 4'b1111;
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("t6_ready_rst", 64'(req_ready_o), 64'd0);
        chk("t6_rom_valid_rst", 64'(rom_valid_o), 64'd0);
        chk("t6_rsp_valid_rst", 64'(rsp_valid_o), 64'd0);
        chk("t6_rsp_f0_rst", rsp_f0_o, 64'd0);
        sb.delete();
        prev_rv   = '0;
        req_valid = '0;
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_err_clear", 64'(err_o), 64'd0);
            chk("t6_no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("t6_first_grant", 64'(req_ready_o), 64'h1);
        req_valid = '0;
        repeat (5) step();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
